trace_match_engine: RTL

//  Trace-clock matcher fed by the TPIU byte deserializer; consumes rule config from the trace register block.

---
 rtl/trace_match_engine_if.sv | 9 +
 rtl/trace_match_engine.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/trace_match_engine_if.sv
// Trace byte stream from the TPIU deserializer into the matcher.
//   I_data        deserialized trace byte
//   I_data_valid  byte valid this cycle; there is no backpressure
interface trace_match_engine_if;
  logic [7:0] I_data;
  logic       I_data_valid;
  modport master (output I_data, output I_data_valid);
  modport slave  (input  I_data, input  I_data_valid);
endinterface

// File: rtl/trace_match_engine.sv
// Trace pattern matcher.
// Accepted bytes shift into a pBUFFER_SIZE-bit window, newest byte in [7:0].
// Once the window holds pBUFFER_SIZE/8 bytes, every accepted byte is evaluated
// against pMATCH_RULES masked patterns one cycle later. The cycle after that,
// the per-rule saturating counters and the trigger are updated.
// Ports:
//   trace_clk, reset_n       clock, async active-low reset
//   i_trc                    byte stream (I_data / I_data_valid)
//   I_synchronized           TPIU sync; low forces IDLE and empties the window
//   I_trace_reset_sync       level clear of the matcher, counters and trigger
//   I_pattern_enable         per-rule enable
//   I_trig_toggle            0 = pulse trigger, 1 = toggle trigger
//   I_trace_trig_enable      arm trigger generation
//   I_capture_rules_mode     1 = one trigger per arming
//   I_pattern_flat/I_mask_flat  rule i at [i*pBUFFER_SIZE +: pBUFFER_SIZE]
//   O_matching_pattern       per-rule result of the latest evaluation
//   O_matching_buffer        window captured at the latest evaluation with a hit
//   O_trace_count_flat       rule i hit counter at [i*8 +: 8]
//   O_trigger, O_armed       trigger output, state == ARMED
module trace_match_engine #(
  parameter int pBUFFER_SIZE = 64,
  parameter int pMATCH_RULES = 8
) (
  input  logic                                 trace_clk,
  input  logic                                 reset_n,
  trace_match_engine_if.slave                  i_trc,
  input  logic                                 I_synchronized,
  input  logic                                 I_trace_reset_sync,
  input  logic [pMATCH_RULES-1:0]              I_pattern_enable,
  input  logic                                 I_trig_toggle,
  input  logic                                 I_trace_trig_enable,
  input  logic                                 I_capture_rules_mode,
  input  logic [pMATCH_RULES*pBUFFER_SIZE-1:0] I_pattern_flat,
  input  logic [pMATCH_RULES*pBUFFER_SIZE-1:0] I_mask_flat,
  output logic [pMATCH_RULES-1:0]              O_matching_pattern,
  output logic [pBUFFER_SIZE-1:0]              O_matching_buffer,
  output logic [8*pMATCH_RULES-1:0]            O_trace_count_flat,
  output logic                                 O_trigger,
  output logic                                 O_armed
);
  localparam int NB = pBUFFER_SIZE / 8;
  localparam int FW = $clog2(NB + 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(NB);
  localparam logic [FW-1:0] FILL_LAST = FW'(NB - 1);

  typedef enum logic [1:0] {IDLE, FILL, ARMED, DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [pBUFFER_SIZE-1:0] r_win;
  logic [FW-1:0]           r_fill;
  // [0]: evaluation due next edge, [1]: count/trigger due next edge
  logic [1:0]              r_vld_pipe;
  logic [pMATCH_RULES-1:0] r_match;
  logic [pBUFFER_SIZE-1:0] r_buf;
  logic                    r_trig;
  logic [pMATCH_RULES-1:0] w_hit;
  logic                    w_accept, w_full_after, w_fire, w_cnt_en;

  assign w_accept     = i_trc.I_data_valid & (r_state != IDLE);
  // fill will be full once this byte lands (NB-1 -> NB, or already saturated)
  assign w_full_after = (r_fill >= FILL_LAST);
  // r_match holds the hits of the evaluation whose count stage is now due
  assign w_fire       = r_vld_pipe[1] & (r_state == ARMED) & (|r_match);
  assign w_cnt_en     = I_synchronized & r_vld_pipe[1] & (r_state != IDLE);

  for (genvar g = 0; g < pMATCH_RULES; g++) begin : g_rule
    logic [pBUFFER_SIZE-1:0] w_pat, w_mask;
    logic [7:0]              r_cnt;
    assign w_pat    = I_pattern_flat[g*pBUFFER_SIZE +: pBUFFER_SIZE];
    assign w_mask   = I_mask_flat[g*pBUFFER_SIZE +: pBUFFER_SIZE];
    assign w_hit[g] = I_pattern_enable[g] & ~(|((r_win ^ w_pat) & w_mask));
    assign O_trace_count_flat[g*8 +: 8] = r_cnt;

    // sync loss keeps counters; only reset_sync clears them
    always_ff @(posedge trace_clk or negedge reset_n) begin
      if (!reset_n)                                      r_cnt <= '0;
      else if (I_trace_reset_sync)                       r_cnt <= '0;
      else if (w_cnt_en && r_match[g] && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win      <= '0;
      r_fill     <= '0;
      r_vld_pipe <= '0;
      r_match    <= '0;
      r_buf      <= '0;
      r_trig     <= 1'b0;
    end else if (I_trace_reset_sync) begin
      r_win      <= '0;
      r_fill     <= '0;
      r_vld_pipe <= '0;
      r_match    <= '0;
      r_buf      <= '0;
      r_trig     <= 1'b0;
    end else if (!I_synchronized) begin
      // in-flight work is dropped; a toggle level holds, a pulse ends
      r_win      <= '0;
      r_fill     <= '0;
      r_vld_pipe <= '0;
      r_trig     <= I_trig_toggle ? r_trig : 1'b0;
    end else begin
      if (w_accept) begin
        r_win <= (r_win << 8) | pBUFFER_SIZE'(i_trc.I_data);
        if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
      end
      r_vld_pipe <= {r_vld_pipe[0], w_accept & w_full_after};
      if (r_vld_pipe[0]) begin
        r_match <= w_hit;
        if (|w_hit) r_buf <= r_win;
      end
      if (w_fire) r_trig <= I_trig_toggle ? ~r_trig : 1'b1;
      else        r_trig <= I_trig_toggle ? r_trig : 1'b0;
    end
  end

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (I_trace_reset_sync || !I_synchronized) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  w_state_nxt = FILL;
        FILL:  if ((r_fill == FILL_MAX) && I_trace_trig_enable) w_state_nxt = ARMED;
        ARMED: if (!I_trace_trig_enable)                   w_state_nxt = FILL;
               else if (w_fire && I_capture_rules_mode)    w_state_nxt = DONE;
        DONE:  if (!I_trace_trig_enable)                   w_state_nxt = FILL;
      endcase
    end
  end

  assign O_matching_pattern = r_match;
  assign O_matching_buffer  = r_buf;
  assign O_trigger          = r_trig;
  assign O_armed            = (r_state == ARMED);
endmodule
